// File: rtl/multi_scale_pkg.sv
// Shared types and helpers for the multi-coefficient shift-add scaler.
//   state_t       : sequencer state (IDLE waits for a sample, EMIT streams products)
//   DEFAULT_COEFS : packed default coefficient vector, index 0 in the low nibble
//   clog2_min1    : index width helper that never returns 0
package multi_scale_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Coefficients 1,3,7,8 for indices 0..3.
    localparam logic [15:0] DEFAULT_COEFS = {4'd8, 4'd7, 4'd3, 4'd1};

    // A single-coefficient build still needs a 1-bit out_idx port.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/shift_add_mul.sv
// Combinational unsigned multiplier built only from shifts and adds.
//   sample  : DATA_W-bit unsigned multiplicand
//   coef    : COEF_W-bit unsigned multiplier
//   product : DATA_W+COEF_W-bit result, cannot overflow
module shift_add_mul #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 4,
    localparam int OUT_W = DATA_W + COEF_W
) (
    input  logic [DATA_W-1:0] sample,
    input  logic [COEF_W-1:0] coef,
    output logic [OUT_W-1:0]  product
);

    // acc[k] holds the partial sum over coefficient bits below k.
    logic [COEF_W:0][OUT_W-1:0] acc;

    assign acc[0] = '0;

    for (genvar k = 0; k < COEF_W; k++) begin : g_term
        assign acc[k+1] = acc[k] + (coef[k] ? (OUT_W'(sample) << k) : OUT_W'(0));
    end

    assign product = acc[COEF_W];

endmodule

// File: rtl/multi_scale_seq.sv
// Accepts one unsigned sample over valid/ready and emits NUM_COEF scaled
// products, one per output beat, in coefficient-index order.
//   clk, rst                  : clock, synchronous active-high reset
//   in_data/in_valid/in_ready : sample handshake (in_ready is combinational)
//   out_data/out_idx/out_last : registered product, its coefficient index,
//                               and end-of-sample marker
//   out_valid/out_ready       : output handshake with backpressure
// A new sample is taken on the same edge that retires the last product, so
// back-to-back samples stream without a bubble.
module multi_scale_seq
    import multi_scale_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int COEF_W   = 4,
    parameter int NUM_COEF = 4,
    parameter logic [NUM_COEF*COEF_W-1:0] COEFS = DEFAULT_COEFS,
    localparam int OUT_W = DATA_W + COEF_W,
    localparam int IDX_W = clog2_min1(NUM_COEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_last,
    output logic              out_valid,
    input  logic              out_ready
);

    state_t              state, state_d;
    logic [DATA_W-1:0]   sample_q;
    logic                accept;
    logic                advance;
    logic                load;
    logic [IDX_W-1:0]    next_idx;
    logic                next_last;
    logic [DATA_W-1:0]   mul_sample;
    logic [COEF_W-1:0]   coef_sel;
    logic [OUT_W-1:0]    product;

    // in_ready in EMIT depends on out_ready so the last beat and the next
    // sample can share one edge.
    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            if (state == IDLE) in_ready = 1'b1;
            else               in_ready = out_last && out_ready;
        end
    end

    assign accept  = in_valid && in_ready;
    assign advance = (state == EMIT) && out_ready && !out_last;
    assign load    = accept || advance;

    // The product for the beat about to be registered: index 0 of the
    // incoming sample on accept, otherwise the next index of the held one.
    assign next_idx   = accept ? '0 : out_idx + IDX_W'(1);
    assign next_last  = (next_idx == IDX_W'(NUM_COEF - 1));
    assign mul_sample = accept ? in_data : sample_q;

    always_comb begin
        coef_sel = '0;
        for (int i = 0; i < NUM_COEF; i++) begin
            if (next_idx == IDX_W'(i)) coef_sel = COEFS[i*COEF_W +: COEF_W];
        end
    end

    shift_add_mul #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W)
    ) u_mul (
        .sample  (mul_sample),
        .coef    (coef_sel),
        .product (product)
    );

    always_comb begin
        state_d = state;
        case (state)
            IDLE: if (accept) state_d = EMIT;
            EMIT: if (out_ready && out_last) state_d = accept ? EMIT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sample_q  <= '0;
            out_idx   <= '0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_d;
            out_valid <= (state_d == EMIT);
            if (accept) sample_q <= in_data;
            if (load) begin
                out_idx  <= next_idx;
                out_data <= product;
                out_last <= next_last;
            end
        end
    end

endmodule
